// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - decode-side and ALU-side handshake bundle for alu_issue
interface alu_issue_if #(
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [RADDR_W-1:0] in_rs_a;
  logic [RADDR_W-1:0] in_rs_b;
  logic [RADDR_W-1:0] in_rd;
  logic [31:0]        in_data_a;
  logic [31:0]        in_data_b;
  logic               in_use_imm;
  logic [31:0]        in_imm;

  logic               out_valid;
  logic               out_ready;
  logic [31:0]        srca;
  logic [31:0]        srcb;
  logic [2:0]         control;
  logic [RADDR_W-1:0] out_rd;

  modport master (
    output in_valid, in_op, in_rs_a, in_rs_b, in_rd, in_data_a, in_data_b,
           in_use_imm, in_imm, out_ready,
    input  in_ready, out_valid, srca, srcb, control, out_rd
  );

  modport slave (
    input  in_valid, in_op, in_rs_a, in_rs_b, in_rd, in_data_a, in_data_b,
           in_use_imm, in_imm, out_ready,
    output in_ready, out_valid, srca, srcb, control, out_rd
  );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - two-entry in-order operand-issue buffer with EX/WB forwarding and snoop
module alu_issue #(
  parameter int DEPTH   = 2,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_if.slave         bus,
  input  logic               ex_wr_en,
  input  logic [RADDR_W-1:0] ex_wr_addr,
  input  logic [31:0]        ex_wr_data,
  input  logic               wb_wr_en,
  input  logic [RADDR_W-1:0] wb_wr_addr,
  input  logic [31:0]        wb_wr_data,
  input  logic               flush
);

  localparam logic [1:0] LP_FULL = 2'(DEPTH);
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_ROT  = 3'b110;

  typedef struct packed {
    logic [2:0]         op;
    logic [RADDR_W-1:0] rs_a;
    logic [RADDR_W-1:0] rs_b;
    logic               use_imm;
    logic [RADDR_W-1:0] rd;
    logic [31:0]        a;
    logic [31:0]        b;
  } entry_t;

  // r_ent0 is always the head; r_ent1 only holds data while r_count == 2
  entry_t     r_ent0;
  entry_t     r_ent1;
  logic [1:0] r_count;

  entry_t     w_new;
  entry_t     w_snp0;
  entry_t     w_snp1;
  logic       w_push;
  logic       w_pop;
  logic       w_in_ready;
  logic       w_out_valid;

  function automatic logic [31:0] f_fwd(input logic [RADDR_W-1:0] rs,
                                        input logic [31:0]        dflt);
    if (rs == '0)
      return 32'h0;
    else if (ex_wr_en && (ex_wr_addr == rs))
      return ex_wr_data;
    else if (wb_wr_en && (wb_wr_addr == rs))
      return wb_wr_data;
    else
      return dflt;
  endfunction

  // Shift amounts only use the low five bits of operand B
  function automatic logic [31:0] f_mask(input logic [2:0]  op,
                                         input logic [31:0] val);
    if ((op == OP_SLL) || (op == OP_ROT))
      return {27'h0, val[4:0]};
    else
      return val;
  endfunction

  function automatic entry_t f_snoop(input entry_t e);
    entry_t u;
    u   = e;
    u.a = f_fwd(e.rs_a, e.a);
    if (!e.use_imm)
      u.b = f_mask(e.op, f_fwd(e.rs_b, e.b));
    return u;
  endfunction

  always_comb begin
    w_in_ready  = (r_count != LP_FULL);
    w_out_valid = (r_count != 2'd0);
    w_push      = bus.in_valid & w_in_ready & ~flush;
    w_pop       = w_out_valid & bus.out_ready & ~flush;

    w_new         = '0;
    w_new.op      = bus.in_op;
    w_new.rs_a    = bus.in_rs_a;
    w_new.rs_b    = bus.in_rs_b;
    w_new.use_imm = bus.in_use_imm;
    w_new.rd      = bus.in_rd;
    w_new.a       = f_fwd(bus.in_rs_a, bus.in_data_a);
    w_new.b       = f_mask(bus.in_op, bus.in_use_imm ? bus.in_imm
                                                     : f_fwd(bus.in_rs_b, bus.in_data_b));

    w_snp0 = f_snoop(r_ent0);
    w_snp1 = f_snoop(r_ent1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      // Live entries track EX/WB writes; empty slots keep their last contents
      if (r_count != 2'd0)
        r_ent0 <= w_snp0;
      if (r_count == 2'd2)
        r_ent1 <= w_snp1;

      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0)
            r_ent0 <= w_new;
          else
            r_ent1 <= w_new;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2)
            r_ent0 <= w_snp1;
          else
            r_ent0 <= r_ent0;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Push with pop only happens at count 1, so the new op becomes head
          r_ent0 <= w_new;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.srca      = r_ent0.a;
  assign bus.srcb      = r_ent0.b;
  assign bus.control   = r_ent0.op;
  assign bus.out_rd    = r_ent0.rd;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Operand-issue stage directly upstream of the 32-bit ALU (ports srca, srcb, control).
- Accepts decoded ops from the decode/register-read stage and resolves operands.
- Forwards in-flight results from the EX and WB stages.
- Buffers up to two ops in order and presents the oldest to the ALU with a valid/ready handshake.

Parameters:
- DEPTH, 2, number of buffered entries; fixed at 2 (skid buffer), other values unsupported.
- RADDR_W, 5, register address width; register 0 reads as zero.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode presents an op
- in_ready  output  1  stage can accept; equals (count < 2)
- in_op  input  3  ALU control code: ADD 000, OR 001, AND 010, XOR 011, NOR 100, SLL 101, ROT 110, SUB 111
- in_rs_a  input  5  source register A
- in_rs_b  input  5  source register B
- in_rd  input  5  destination register, passed through
- in_data_a  input  32  register-file read value for rs_a
- in_data_b  input  32  register-file read value for rs_b
- in_use_imm  input  1  operand B is in_imm, no forwarding applied to B
- in_imm  input  32  immediate
- ex_wr_en  input  1  EX-stage result valid for writeback
- ex_wr_addr  input  5  EX destination
- ex_wr_data  input  32  EX result
- wb_wr_en  input  1  WB-stage write enable
- wb_wr_addr  input  5  WB destination
- wb_wr_data  input  32  WB data
- flush  input  1  synchronous discard of all buffered ops
- out_valid  output  1  head entry valid
- out_ready  input  1  ALU side consumes head
- srca  output  32  operand A of head entry
- srcb  output  32  operand B of head entry
- control  output  3  op code of head entry
- out_rd  output  5  destination of head entry

Behaviour:
- Reset (rst_n low, asynchronous): count=0, both entries invalid, out_valid=0, srca=srcb=0, control=000, out_rd=0. in_ready=1 once count=0.
- Push: in_valid & in_ready & !flush at a rising edge writes the tail entry. Pop: out_valid & out_ready at a rising edge retires the head.
- Push and pop in the same cycle: count unchanged, order preserved.
- Latency: op accepted at edge N with the buffer empty gives out_valid=1 after edge N. Sustained throughput is 1 op/cycle while out_ready=1.
- Full (count=2): in_ready=0, in_valid ignored. Empty: out_valid=0 and outputs hold the last popped values (don't-care for the consumer).
- Capture forwarding, per operand: if rs==0, value 0. Else if ex_wr_en & ex_wr_addr==rs, ex_wr_data. Else if wb_wr_en & wb_wr_addr==rs, wb_wr_data. Else in_data. EX has priority over WB.
- Snoop: every cycle, each valid buffered entry whose operand is register-sourced (rs!=0; for B also !use_imm) and matches ex/wb writes replaces its stored value, with the same priority. The update is visible on outputs the next cycle. An entry popped in the same cycle is not updated.
- Shift ops (SLL, ROT): stored srcb has bits [31:5] forced to 0, applied after forwarding/immediate selection and again on snoop update.
- Flush: at the edge it is sampled high, count becomes 0 and out_valid becomes 0. A simultaneous push or pop is discarded. Flush has priority over everything except reset.
- Reset mid-operation discards all entries immediately. No partial state survives.
- Outputs are driven from the head entry registers; there is no combinational path from in_* to srca/srcb/control.

Test Plan:
- Reset then single op: in_op=000, rs_a=1 (data 5), rs_b=2 (data 7), rd=3, out_ready=1 -> next cycle out_valid=1, srca=5, srcb=7, control=000, out_rd=3; then out_valid=0.
- Forward priority: rs_a=4, ex_wr_en=1 addr=4 data=0x11, wb_wr_en=1 addr=4 data=0x22 -> srca=0x11. Same case with ex_wr_en=0 -> srca=0x22. rs_a=0 with ex write to 0 -> srca=0.
- Backpressure: out_ready=0, push 3 ops (A, B, C) -> in_ready=0 after the second accept, C not accepted. Raise out_ready -> A then B pop in order; C is accepted once in_ready=1.
- Snoop while stalled: op with rs_b=6 held (out_ready=0); then wb_wr_en=1 addr=6 data=0xABCD -> srcb=0xABCD next cycle. With in_use_imm=1 (imm=0x10) the same write leaves srcb=0x10.
- Shift mask: in_op=101, use_imm=1, imm=0xFFFF_FFE3 -> srcb=0x0000_0003.
- Flush with 2 entries plus simultaneous in_valid -> out_valid=0, in_ready=1 next cycle, no op emitted. Assert rst_n=0 mid-stream -> outputs are reset values immediately.
